// File: rtl/reg_file.sv
// ============================================================================
//  Module   : reg_file
//  Purpose  : MIPS register file with two combinational read ports and one
//             synchronous write port. Register 0 is hard-wired to zero.
//             Optional macro REGFILE_BYPASS_EN adds write-first forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
   parameter int N_bit  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   input  logic [ADDR_W-1:0] A3,
   input  logic              WE3,
   input  logic [N_bit-1:0]  WD3,
   output logic [N_bit-1:0]  RD1,
   output logic [N_bit-1:0]  RD2
);

   localparam int c_depth = 2 ** ADDR_W;

   logic [N_bit-1:0] w_mem [0:c_depth-1];
   logic             w_wr_any;

   assign w_wr_any = WE3 && (A3 != '0);

   // Entry 0 is a constant, never a flop.
   assign w_mem[0] = '0;

   genvar gi;
   generate
      for (gi = 1; gi < c_depth; gi = gi + 1) begin : g_reg
         logic [N_bit-1:0] r_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_q <= '0;
            end else if (w_wr_any && (A3 == ADDR_W'(gi))) begin
               r_q <= WD3;
            end
         end

         assign w_mem[gi] = r_q;
      end
   endgenerate

`ifdef REGFILE_BYPASS_EN
   logic w_fwd1;
   logic w_fwd2;

   assign w_fwd1 = w_wr_any && (A1 == A3);
   assign w_fwd2 = w_wr_any && (A2 == A3);

   // Reset must dominate the forwarded write data.
   always_comb begin
      RD1 = w_mem[A1];
      RD2 = w_mem[A2];
      if (w_fwd1) RD1 = WD3;
      if (w_fwd2) RD2 = WD3;
      if (reset) begin
         RD1 = '0;
         RD2 = '0;
      end
   end
`else
   assign RD1 = w_mem[A1];
   assign RD2 = w_mem[A2];
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
//  Module   : tb_reg_file
//  Purpose  : Scoreboard bench for reg_file; stimulus queues expected reads,
//             a monitor process pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

   localparam int N_bit  = 32;
   localparam int ADDR_W = 5;

   logic              clk;
   logic              reset;
   logic [ADDR_W-1:0] A1, A2, A3;
   logic              WE3;
   logic [N_bit-1:0]  WD3;
   logic [N_bit-1:0]  RD1, RD2;

   typedef struct {
      string           name;
      logic [N_bit-1:0] rd1;
      logic [N_bit-1:0] rd2;
   } exp_t;

   exp_t q[$];
   event chk_ev;
   int   checks = 0;
   int   errors = 0;

   reg_file #(.N_bit(N_bit), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .A1    (A1),
      .A2    (A2),
      .A3    (A3),
      .WE3   (WE3),
      .WD3   (WD3),
      .RD1   (RD1),
      .RD2   (RD2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: pops one expectation per strobe and compares both read ports.
   initial begin
      exp_t e;
      forever begin
         @(chk_ev);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: strobe with no expectation queued");
         end else begin
            e = q.pop_front();
            checks++;
            if (RD1 !== e.rd1) begin
               errors++;
               $display("FAIL %s RD1: got %h expected %h", e.name, RD1, e.rd1);
            end
            checks++;
            if (RD2 !== e.rd2) begin
               errors++;
               $display("FAIL %s RD2: got %h expected %h", e.name, RD2, e.rd2);
            end
         end
      end
   end

   task automatic expect_rd(input string name, input logic [N_bit-1:0] e1,
                            input logic [N_bit-1:0] e2);
      exp_t e;
      e.name = name;
      e.rd1  = e1;
      e.rd2  = e2;
      q.push_back(e);
      #1;
      -> chk_ev;
      #1;
   endtask

   // Drives a write at a negedge; it lands on the following posedge.
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [N_bit-1:0] d);
      @(negedge clk);
      WE3 = 1'b1;
      A3  = a;
      WD3 = d;
      @(negedge clk);
      WE3 = 1'b0;
   endtask

   logic [N_bit-1:0] exp_byp;

   initial begin
      reset = 1'b1;
      A1 = 5'd5; A2 = 5'd31; A3 = '0; WE3 = 1'b0; WD3 = '0;

      // 1: reset holds everything at zero, including a write attempted under reset
      expect_rd("reset_read", 32'h0, 32'h0);
      WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF;
      @(negedge clk);
      expect_rd("reset_vs_write", 32'h0, 32'h0);
      WE3 = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      expect_rd("post_reset_reg5", 32'h0, 32'h0);

      // 2: basic write then hold with WE3=0
      do_write(5'd9, 32'h0000000A);
      A1 = 5'd9;
      expect_rd("write_reg9", 32'h0000000A, 32'h0);
      WD3 = 32'hFFFFFFFF;
      @(negedge clk);
      expect_rd("we_low_hold", 32'h0000000A, 32'h0);

      // 3: writes to register 0 are dropped
      do_write(5'd0, 32'h12345678);
      A1 = 5'd0; A2 = 5'd0;
      expect_rd("reg0_zero", 32'h0, 32'h0);

      // 4: same-cycle read/write, read-old vs bypass
      do_write(5'd3, 32'h00000011);
      @(negedge clk);
      WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h00000022; A1 = 5'd3; A2 = 5'd3;
`ifdef REGFILE_BYPASS_EN
      exp_byp = 32'h00000022;
`else
      exp_byp = 32'h00000011;
`endif
      expect_rd("rw_same_pre", exp_byp, exp_byp);
      @(negedge clk);
      WE3 = 1'b0;
      expect_rd("rw_same_post", 32'h00000022, 32'h00000022);

      // 5: fill and sweep every address
      for (int i = 1; i < 32; i++) do_write(ADDR_W'(i), 32'(i * 3));
      for (int i = 0; i < 32; i++) begin
         A1 = ADDR_W'(i);
         A2 = ADDR_W'(31 - i);
         expect_rd("sweep", 32'(i * 3), 32'((31 - i) * 3));
      end

      // 6: asynchronous mid-cycle reset pulse
      do_write(5'd7, 32'hA5A5A5A5);
      A1 = 5'd7; A2 = 5'd31;
      expect_rd("reg7_before_reset", 32'hA5A5A5A5, 32'd93);
      @(negedge clk);
      #1 reset = 1'b1;
      expect_rd("async_reset", 32'h0, 32'h0);
      reset = 1'b0;
      expect_rd("after_async_reset", 32'h0, 32'h0);
      A1 = 5'd3; A2 = 5'd9;
      expect_rd("all_cleared", 32'h0, 32'h0);

      #2;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
